digit_entry_ctrl: RTL
=====================

Name: digit_entry_ctrl

Overview:
- Parametrised front-panel operand entry controller for the Basys3 CPU demos.
- Maintains NUM_DIGITS editable BCD digits with a cursor, and auto-repeats held up/down keys.
- On a go command it converts the digits into NUM_OPS binary operands, one digit per cycle, then raises a start request to the CPU domain and holds it until acknowledged.
- It generalises the fixed 4-digit / two-operand / single-step panel logic to any digit count, operand count and width.

Parameters:
- NUM_DIGITS, 4: total editable decimal digits; must be a multiple of NUM_OPS.
- NUM_OPS, 2: number of operands; each operand takes D = NUM_DIGITS/NUM_OPS digits.
- OP_W, 32: operand width in bits; must satisfy 10^D - 1 < 2^OP_W.
- REPEAT_DLY, 30_000_000: cycles a key must be held after its press edge before the first auto-repeat.
- REPEAT_RATE, 10_000_000: cycles between later auto-repeats.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- up_lvl  in  1  debounced level of the up key.
- down_lvl  in  1  debounced level of the down key.
- left_pulse  in  1  one-cycle debounced pulse; moves the cursor one digit left.
- right_pulse  in  1  one-cycle debounced pulse; moves the cursor one digit right.
- go_pulse  in  1  one-cycle pulse; starts conversion.
- clear_pulse  in  1  one-cycle pulse; clears all digits and aborts any operation.
- start_ack  in  1  CPU-side acknowledge of start_req.
- digits  out  4*NUM_DIGITS  BCD digits; digit 0 is in bits [3:0] and is the rightmost digit.
- cursor  out  $clog2(NUM_DIGITS)  index of the selected digit.
- operands  out  NUM_OPS*OP_W  operand k is in bits [(k+1)*OP_W-1 : k*OP_W].
- ops_valid  out  1  operands match the current digits.
- start_req  out  1  start request level.
- busy  out  1  high in CONVERT or REQ.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - All digits = 0, cursor = 0, operands = 0.
  - ops_valid = 0, start_req = 0, busy = 0, state = EDIT.
  - Repeat counters are cleared.
  - rst overrides every other input, including mid-CONVERT and mid-REQ.
- States: EDIT, CONVERT, REQ.
- EDIT:
  - left_pulse: cursor = (cursor == NUM_DIGITS-1) ? 0 : cursor+1.
  - right_pulse: cursor = (cursor == 0) ? NUM_DIGITS-1 : cursor-1.
  - left_pulse and right_pulse in the same cycle: cursor unchanged.
  - Inc event: digits[cursor] = (digit == 9) ? 0 : digit+1.
  - Dec event: digits[cursor] = (digit == 0) ? 9 : digit-1.
  - A digit edit and a cursor move in the same cycle: the edit applies to the old cursor position.
  - Any digit change clears ops_valid in the following cycle.
  - go_pulse: go to CONVERT next cycle and clear all operand accumulators. Edits in the same cycle as go are still applied.
- Auto-repeat (one instance per key):
  - A rising edge of the key level produces one event in the edge cycle.
  - If the key is still held REPEAT_DLY cycles after the edge, another event fires, then one every REPEAT_RATE cycles while held.
  - Releasing the key resets the repeat counter.
  - up_lvl and down_lvl both high: no events from either key, and both counters reset.
  - Events are ignored outside EDIT, but counters keep running.
- CONVERT (exactly D cycles, i = 0..D-1):
  - Every operand k updates in parallel: acc_k = acc_k*10 + digits[k*D + D-1-i], with the most significant digit first.
  - acc*10 is implemented as (acc<<3) + (acc<<1), truncated to OP_W; overflow is impossible by the parameter constraint.
  - Digits are frozen during CONVERT.
  - After the last cycle, operands are loaded, ops_valid = 1, state = REQ.
- Latency: go_pulse at cycle t gives CONVERT during t+1 .. t+D, and start_req = 1 from t+D+1.
- REQ:
  - start_req stays high until start_ack is sampled high.
  - On that edge: start_req = 0 and state = EDIT. start_ack is ignored outside REQ.
  - go_pulse is ignored while busy.
- clear_pulse, in any state:
  - All digits = 0, cursor = 0, ops_valid = 0, start_req = 0, state = EDIT. Operands keep their last value.
  - clear_pulse has priority over go, edits and start_ack.
- busy = (state != EDIT). All outputs are registered.

Decomposition:
- Package digit_entry_pkg holds:
  - the state enum {EDIT, CONVERT, REQ};
  - BCD_MAX = 4'd9;
  - a function for the digits-per-operand constant;
  - the parameter-legality check, which triggers a $fatal on violation.
- Sub-module key_repeat handles edge detect plus the REPEAT_DLY/REPEAT_RATE counter. It has ports clk, rst, lvl, inhibit, evt, and is instantiated for up and down, with inhibit = up_lvl & down_lvl.

Test Plan:
- Bench parameters: NUM_DIGITS=4, NUM_OPS=2, OP_W=32, REPEAT_DLY=20, REPEAT_RATE=5.
- Scenario 1: after reset, press left 3 times, then up 4 times with short presses -> cursor = 3, digits = 0x4000. Then right once -> cursor = 2. Then left from 3 -> cursor wraps to 0.
- Scenario 2: at digit 0, issue down -> digit = 9. Hold up for 31 cycles -> 4 events (edge, +20, +25, +30), so digit = 9+4 mod 10 = 3. up and down held together -> digit unchanged.
- Scenario 3: digits 0x4812, go at cycle t -> busy at t+1, start_req at t+3, operands = {48, 12}, ops_valid = 1. Hold start_ack low for 10 cycles -> start_req stays high. Then ack -> start_req = 0, EDIT next cycle.
- Scenario 4: edit a digit after a completed conversion -> ops_valid = 0 next cycle, operands unchanged. Issue go while in REQ -> ignored.
- Scenario 5: with digits 0x9999, issue clear_pulse mid-CONVERT -> state EDIT, digits 0, start_req never asserted. Re-enter 99/99 and convert -> operands = 99, 99.
- Scenario 6: assert rst during REQ -> all outputs 0 the next cycle. Re-run with NUM_DIGITS=8, NUM_OPS=2, digits 12345678 -> operands {1234, 5678} after 4 convert cycles.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared types, constants and elaboration-time helpers for the digit entry panel.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    EDIT    = 2'd0,
    CONVERT = 2'd1,
    REQ     = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Decimal digits that make up one operand.
  function automatic int unsigned digits_per_op(input int unsigned nd, input int unsigned nops);
    return nd / nops;
  endfunction

  // True when the parameter set is buildable: digits split evenly, the largest
  // D-digit decimal fits in op_w bits, and both repeat intervals are non-zero.
  function automatic bit params_legal(input int unsigned nd, input int unsigned nops,
                                      input int unsigned op_w, input int unsigned dly,
                                      input int unsigned rate);
    longint unsigned lim;
    int unsigned     d;
    if (nops == 0 || nd < 2 || (nd % nops) != 0) return 1'b0;
    if (op_w == 0 || dly == 0 || rate == 0) return 1'b0;
    d = nd / nops;
    if (op_w >= 64) return 1'b1;
    if (d > 19) return 1'b0;
    lim = 64'd1;
    for (int unsigned i = 0; i < d; i++) lim = lim * 64'd10;
    return ((lim - 64'd1) >> op_w) == 64'd0;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detect plus hold-to-repeat event generator for one key level.
module key_repeat #(
  parameter int unsigned REPEAT_DLY  = 30_000_000,
  parameter int unsigned REPEAT_RATE = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  input  logic inhibit,
  output logic evt
);

  localparam int unsigned MAXC  = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);

  logic             r_prev;
  logic             r_rep;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_target;
  logic             w_edge;
  logic             w_hit;

  // r_cnt holds cycles elapsed since the press edge or since the last repeat.
  assign w_target = r_rep ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DLY);
  assign w_edge   = lvl & ~r_prev;
  assign w_hit    = lvl & r_prev & (r_cnt == w_target);
  // Strobe is combinational so the press edge acts in the same cycle.
  assign evt      = ~inhibit & (w_edge | w_hit);

  // Track previous level and the repeat interval counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= lvl;
      if (inhibit || !lvl) begin
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (w_edge) begin
        r_rep <= 1'b0;
        r_cnt <= CNT_W'(1);
      end else if (w_hit) begin
        r_rep <= 1'b1;
        r_cnt <= CNT_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Front-panel BCD operand entry: cursor editing, BCD-to-binary conversion, start handshake.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned NUM_OPS     = 2,
  parameter int unsigned OP_W        = 32,
  parameter int unsigned REPEAT_DLY  = 30_000_000,
  parameter int unsigned REPEAT_RATE = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_lvl,
  input  logic                          down_lvl,
  input  logic                          left_pulse,
  input  logic                          right_pulse,
  input  logic                          go_pulse,
  input  logic                          clear_pulse,
  input  logic                          start_ack,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [$clog2(NUM_DIGITS)-1:0] cursor,
  output logic [NUM_OPS*OP_W-1:0]       operands,
  output logic                          ops_valid,
  output logic                          start_req,
  output logic                          busy
);

  localparam int unsigned D      = digits_per_op(NUM_DIGITS, NUM_OPS);
  localparam int unsigned CUR_W  = $clog2(NUM_DIGITS);
  localparam int unsigned STEP_W = (D > 1) ? $clog2(D) : 1;

  if (!params_legal(NUM_DIGITS, NUM_OPS, OP_W, REPEAT_DLY, REPEAT_RATE)) begin : g_param_check
    $fatal(1, "digit_entry_ctrl: illegal parameter combination");
  end

  state_t                    r_state;
  logic [3:0]                r_dig [NUM_DIGITS];
  logic [CUR_W-1:0]          r_cursor;
  logic [OP_W-1:0]           r_acc [NUM_OPS];
  logic [NUM_OPS*OP_W-1:0]   r_operands;
  logic [STEP_W-1:0]         r_step;
  logic                      r_ops_valid;
  logic                      r_start_req;
  logic                      r_busy;

  logic                      w_inc;
  logic                      w_dec;
  logic                      w_inhibit;
  logic [3:0]                w_cur_dig;
  logic [3:0]                w_inc_dig;
  logic [3:0]                w_dec_dig;
  logic [OP_W-1:0]           w_next [NUM_OPS];

  assign w_inhibit = up_lvl & down_lvl;

  key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up (
    .clk     (clk),
    .rst     (rst),
    .lvl     (up_lvl),
    .inhibit (w_inhibit),
    .evt     (w_inc)
  );

  key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_rep_down (
    .clk     (clk),
    .rst     (rst),
    .lvl     (down_lvl),
    .inhibit (w_inhibit),
    .evt     (w_dec)
  );

  assign w_cur_dig = r_dig[r_cursor];
  assign w_inc_dig = (w_cur_dig == BCD_MAX) ? 4'd0 : w_cur_dig + 4'd1;
  assign w_dec_dig = (w_cur_dig == 4'd0) ? BCD_MAX : w_cur_dig - 4'd1;

  // One multiply-accumulate step per operand, most significant digit first.
  always_comb begin
    for (int k = 0; k < NUM_OPS; k++) begin
      w_next[k] = (r_acc[k] << 3) + (r_acc[k] << 1)
                + OP_W'(r_dig[CUR_W'(k * D + D - 1) - CUR_W'(r_step)]);
    end
  end

  // Panel state machine: edit, convert, and hold the start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EDIT;
      r_cursor    <= '0;
      r_operands  <= '0;
      r_step      <= '0;
      r_ops_valid <= 1'b0;
      r_start_req <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) r_dig[k] <= 4'd0;
      for (int k = 0; k < NUM_OPS; k++) r_acc[k] <= '0;
    end else if (clear_pulse) begin
      r_state     <= EDIT;
      r_cursor    <= '0;
      r_step      <= '0;
      r_ops_valid <= 1'b0;
      r_start_req <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) r_dig[k] <= 4'd0;
    end else begin
      case (r_state)
        EDIT: begin
          // Edits use the cursor value from before any move in this cycle.
          if (w_inc) begin
            r_dig[r_cursor] <= w_inc_dig;
            r_ops_valid     <= 1'b0;
          end else if (w_dec) begin
            r_dig[r_cursor] <= w_dec_dig;
            r_ops_valid     <= 1'b0;
          end
          if (left_pulse && !right_pulse) begin
            r_cursor <= (r_cursor == CUR_W'(NUM_DIGITS - 1)) ? '0 : r_cursor + CUR_W'(1);
          end else if (right_pulse && !left_pulse) begin
            r_cursor <= (r_cursor == '0) ? CUR_W'(NUM_DIGITS - 1) : r_cursor - CUR_W'(1);
          end
          if (go_pulse) begin
            r_state <= CONVERT;
            r_busy  <= 1'b1;
            r_step  <= '0;
            for (int k = 0; k < NUM_OPS; k++) r_acc[k] <= '0;
          end
        end
        CONVERT: begin
          for (int k = 0; k < NUM_OPS; k++) r_acc[k] <= w_next[k];
          if (r_step == STEP_W'(D - 1)) begin
            for (int k = 0; k < NUM_OPS; k++) r_operands[k*OP_W +: OP_W] <= w_next[k];
            r_ops_valid <= 1'b1;
            r_start_req <= 1'b1;
            r_state     <= REQ;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        REQ: begin
          if (start_ack) begin
            r_start_req <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= EDIT;
          end
        end
        default: begin
          r_state     <= EDIT;
          r_start_req <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig_out
    assign digits[g*4 +: 4] = r_dig[g];
  end

  assign cursor    = r_cursor;
  assign operands  = r_operands;
  assign ops_valid = r_ops_valid;
  assign start_req = r_start_req;
  assign busy      = r_busy;

endmodule
